// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 valid/ready stream demultiplexer with broadcast.
// Each lane owns a one-entry holding register, so a stalled lane blocks only words aimed at it.
module demux4_stream #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_sel,
  input  logic           in_bcast,
  input  logic [W-1:0]   in_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data,
  output logic [2:0]     occupancy
);

  logic [3:0]   valid_r;
  logic [W-1:0] data_r [4];
  logic [2:0]   occ_r;

  logic [3:0]   can_take_s;
  logic [3:0]   target_s;
  logic [3:0]   load_s;
  logic [3:0]   valid_nxt_s;
  logic         in_ready_s;
  logic         accept_s;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Acceptance and next lane state; in_ready never looks at in_valid.
  always_comb begin
    can_take_s = ~valid_r | out_ready;
    if (in_bcast) begin
      in_ready_s = &can_take_s;
      target_s   = 4'b1111;
    end else begin
      in_ready_s = can_take_s[in_sel];
      target_s   = 4'b0001 << in_sel;
    end
    accept_s    = in_valid & in_ready_s;
    load_s      = {4{accept_s}} & target_s;
    // A load wins over a drain, so a same-cycle drain and fill keeps the lane valid.
    valid_nxt_s = load_s | (valid_r & ~out_ready);
  end

  // Lane holding registers and occupancy, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 4'b0000;
      occ_r   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        data_r[i] <= {W{1'b0}};
      end
    end else begin
      valid_r <= valid_nxt_s;
      occ_r   <= popcount4(valid_nxt_s);
      for (int i = 0; i < 4; i++) begin
        if (load_s[i]) begin
          data_r[i] <= in_data;
        end else begin
          data_r[i] <= data_r[i];
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign out_data[g*W +: W] = data_r[g];
    end
  endgenerate

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_demux4_stream.sv
// Testbench for demux4_stream: directed scenarios plus a randomized run
// checked against a queue-per-lane reference model.
module tb_demux4_stream;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_sel;
  logic           in_bcast;
  logic [W-1:0]   in_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [2:0]     occupancy;

  int vectors = 0;
  int miscompares = 0;

  demux4_stream #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_bcast = b;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 4'b0000;
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    tick();
    vectors++;
    if (out_valid !== 4'b0000 || occupancy !== 3'd0 || out_data !== {4*W{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_init: valid=%b occ=%0d data=%h required valid=0000 occ=0 data=0", out_valid, occupancy, out_data);
    end
    rst = 1'b0;
    drive(1'b1, 2'd1, 1'b0, 32'h1111_0001);
    tick();
    drive(1'b1, 2'd3, 1'b0, 32'h3333_0003);
    tick();
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    #1;
    vectors++;
    if (out_valid !== 4'b1010 || occupancy !== 3'd2 || lane(1) !== 32'h1111_0001 || lane(3) !== 32'h3333_0003) begin
      miscompares++;
      $display("FAIL reset_fill: valid=%b occ=%0d l1=%h l3=%h required 1010 2 11110001 33330003", out_valid, occupancy, lane(1), lane(3));
    end
    #1;
    rst = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 32'hDEAD_0000);
    #1;
    vectors++;
    if (out_valid !== 4'b0000 || occupancy !== 3'd0 || out_data !== {4*W{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_async: valid=%b occ=%0d required valid=0000 occ=0", out_valid, occupancy);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0000 || occupancy !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_no_accept: valid=%b occ=%0d required 0000 0", out_valid, occupancy);
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_unicast();
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b0, 32'hA0 + 32'(i));
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL unicast_ready[%0d]: got %b required 1", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== (4'b0001 << i) || lane(i) !== 32'hA0 + 32'(i)) begin
        miscompares++;
        $display("FAIL unicast_lane[%0d]: valid=%b data=%h required valid=%b data=%h", i, out_valid, lane(i), 4'b0001 << i, 32'hA0 + 32'(i));
      end
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    vectors++;
    if (out_valid !== 4'b0000 || occupancy !== 3'd0) begin
      miscompares++;
      $display("FAIL unicast_drain: valid=%b occ=%0d required 0000 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    drive(1'b1, 2'd2, 1'b0, 32'h11);
    tick();
    drive(1'b1, 2'd2, 1'b0, 32'h22);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall_ready: got %b required 0", in_ready);
    end
    drive(1'b1, 2'd0, 1'b0, 32'h33);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_other_lane_ready: got %b required 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0101 || lane(0) !== 32'h33 || lane(2) !== 32'h11) begin
      miscompares++;
      $display("FAIL bp_hold: valid=%b l0=%h l2=%h required 0101 33 11", out_valid, lane(0), lane(2));
    end
    drive(1'b1, 2'd2, 1'b0, 32'h22);
    tick();
    vectors++;
    if (out_valid !== 4'b0100 || lane(2) !== 32'h11) begin
      miscompares++;
      $display("FAIL bp_stable: valid=%b l2=%h required 0100 11", out_valid, lane(2));
    end
    out_ready = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0100 || lane(2) !== 32'h22) begin
      miscompares++;
      $display("FAIL bp_release_data: valid=%b l2=%h required 0100 22", out_valid, lane(2));
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_drain_fill();
    out_ready = 4'b0000;
    drive(1'b1, 2'd1, 1'b0, 32'h44);
    tick();
    out_ready = 4'b0010;
    drive(1'b1, 2'd1, 1'b0, 32'h55);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL df_ready: got %b required 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0010 || lane(1) !== 32'h55) begin
      miscompares++;
      $display("FAIL df_data: valid=%b l1=%h required 0010 55", out_valid, lane(1));
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL df_drain: valid=%b required 0000", out_valid);
    end
  endtask

  task automatic test_broadcast();
    out_ready = 4'b0000;
    drive(1'b1, 2'd3, 1'b0, 32'h77);
    tick();
    out_ready = 4'b0111;
    drive(1'b1, 2'd0, 1'b1, 32'hBEEF);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bc_stall_ready: got %b required 0", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b1000 || lane(3) !== 32'h77 || occupancy !== 3'd1) begin
      miscompares++;
      $display("FAIL bc_no_partial: valid=%b l3=%h occ=%0d required 1000 77 1", out_valid, lane(3), occupancy);
    end
    out_ready = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bc_release_ready: got %b required 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b1111 || occupancy !== 3'd4 || lane(0) !== 32'hBEEF || lane(1) !== 32'hBEEF ||
        lane(2) !== 32'hBEEF || lane(3) !== 32'hBEEF) begin
      miscompares++;
      $display("FAIL bc_all: valid=%b occ=%0d data=%h required 1111 4 all BEEF", out_valid, occupancy, out_data);
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] mq [4][$];
    logic [3:0]   can;
    logic         exp_rdy;
    int           held;
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 8) == 0, $urandom);
      out_ready = 4'($urandom);
      #1;
      held = 0;
      for (int i = 0; i < 4; i++) begin
        can[i] = (mq[i].size() == 0) || out_ready[i];
        held += mq[i].size();
      end
      exp_rdy = in_bcast ? (can == 4'b1111) : can[in_sel];
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_ready cyc %0d: got %b required %b", c, in_ready, exp_rdy);
      end
      vectors++;
      if (occupancy !== 3'(held)) begin
        miscompares++;
        $display("FAIL rnd_occ cyc %0d: got %0d required %0d", c, occupancy, held);
      end
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (out_valid[i] !== (mq[i].size() != 0) || (mq[i].size() != 0 && lane(i) !== mq[i][0])) begin
          miscompares++;
          $display("FAIL rnd_lane%0d cyc %0d: valid=%b data=%h required valid=%b data=%h", i, c,
                   out_valid[i], lane(i), mq[i].size() != 0, (mq[i].size() != 0) ? mq[i][0] : 32'h0);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (out_ready[i] && mq[i].size() != 0) void'(mq[i].pop_front());
        if (in_valid && exp_rdy && (in_bcast || in_sel == 2'(i))) mq[i].push_back(in_data);
      end
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    out_ready = 4'b1111;
    tick();
    vectors++;
    if (out_valid !== 4'b0000 || occupancy !== 3'd0) begin
      miscompares++;
      $display("FAIL rnd_final_drain: valid=%b occ=%0d required 0000 0", out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_drain_fill();
    test_broadcast();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
